// File: rtl/fp_conv_scheduler.sv
// rtl/fp_conv_scheduler.sv - per-sample round-robin scheduler sharing one pipelined int-to-FP converter
module fp_conv_scheduler #(
  parameter int N        = 4,
  parameter int DW       = 13,
  parameter int FPW      = 64,
  parameter int CONV_LAT = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_Fs,
  input  logic [N-1:0]      ch_en,
  input  logic [N-1:0]      req,
  input  logic [N*DW-1:0]   ch_data,
  output logic [N-1:0]      ack,
  output logic              conv_en,
  output logic [DW-1:0]     conv_in,
  input  logic [FPW-1:0]    conv_result,
  output logic              res_valid,
  output logic [2:0]        res_ch,
  output logic [FPW-1:0]    res_out,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, SERVE, DRAIN, DONE} state_t;

  state_t           state;
  logic             fs_q;
  logic             fs_rise;
  logic [N-1:0]     pending;
  logic [2:0]       rr_ptr;
  logic [7:0]       elig8;
  logic             found;
  logic [2:0]       pick;
  logic [3:0]       sum4;
  logic [N-1:0]     grant_mask;
  logic [DW-1:0]    sel_data;
  logic             grant;
  logic [2:0]       rr_next;
  logic [CONV_LAT:0] tag_v;
  logic [2:0]       tag_ch [0:CONV_LAT];

  assign fs_rise = clk_Fs & ~fs_q;
  assign elig8   = 8'(pending & req);
  assign grant   = (state == SERVE) && found;
  assign rr_next = (pick == 3'(N-1)) ? 3'd0 : pick + 3'd1;

  // First eligible channel at or above rr_ptr, wrapping modulo N.
  always_comb begin
    found      = 1'b0;
    pick       = '0;
    sum4       = '0;
    grant_mask = '0;
    sel_data   = '0;
    for (int k = 0; k < N; k++) begin
      sum4 = {1'b0, rr_ptr} + 4'(k);
      if (sum4 >= 4'(N)) sum4 = sum4 - 4'(N);
      if (!found && elig8[sum4[2:0]]) begin
        found = 1'b1;
        pick  = sum4[2:0];
      end
    end
    for (int i = 0; i < N; i++) begin
      grant_mask[i] = found && (pick == 3'(i));
      if (pick == 3'(i)) sel_data = ch_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fs_q       <= 1'b0;
      pending    <= '0;
      rr_ptr     <= '0;
      ack        <= '0;
      conv_en    <= 1'b0;
      conv_in    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      tag_v      <= '0;
      for (int k = 0; k <= CONV_LAT; k++) tag_ch[k] <= '0;
    end else begin
      fs_q       <= clk_Fs;
      ack        <= '0;
      conv_en    <= 1'b0;
      frame_done <= 1'b0;
      // Tag stage 0 lines up with the registered conv_en of the same issue.
      tag_v      <= {tag_v[CONV_LAT-1:0], grant};
      tag_ch[0]  <= pick;
      for (int k = 1; k <= CONV_LAT; k++) tag_ch[k] <= tag_ch[k-1];
      if (fs_rise && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (fs_rise) begin
            if (ch_en != '0) begin
              pending <= ch_en;
              state   <= SERVE;
            end else begin
              frame_done <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (found) begin
            ack     <= grant_mask;
            conv_en <= 1'b1;
            conv_in <= sel_data;
            pending <= pending & ~grant_mask;
            rr_ptr  <= rr_next;
            if ((pending & ~grant_mask) == '0) state <= DRAIN;
          end else if (pending == '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Includes the output stage, so frame_done lands after the last result.
          if (tag_v == '0) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign res_valid = tag_v[CONV_LAT];
  assign res_ch    = tag_ch[CONV_LAT];
  assign res_out   = res_valid ? conv_result : '0;

endmodule

// File: tb/tb_fp_conv_scheduler.sv
// tb/tb_fp_conv_scheduler.sv - directed self-checking bench for fp_conv_scheduler
module tb_fp_conv_scheduler;
  localparam int N = 4, DW = 13, FPW = 64, L = 6;

  logic clk = 1'b0;
  logic rst_n, clk_Fs;
  logic [N-1:0] ch_en, req, ack;
  logic [N*DW-1:0] ch_data;
  logic conv_en, res_valid, frame_done, busy, overrun;
  logic [DW-1:0] conv_in;
  logic [FPW-1:0] conv_result, res_out;
  logic [2:0] res_ch;

  fp_conv_scheduler #(.N(N), .DW(DW), .FPW(FPW), .CONV_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .clk_Fs(clk_Fs), .ch_en(ch_en), .req(req),
    .ch_data(ch_data), .ack(ack), .conv_en(conv_en), .conv_in(conv_in),
    .conv_result(conv_result), .res_valid(res_valid), .res_ch(res_ch),
    .res_out(res_out), .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Converter stand-in: integer to IEEE double, L cycles after conv_en.
  logic [63:0] cpipe [0:L-1];
  always @(posedge clk) begin
    cpipe[0] <= $realtobits($itor($signed(conv_in)));
    for (int k = 1; k < L; k++) cpipe[k] <= cpipe[k-1];
  end
  assign conv_result = cpipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  int ack_cyc[$], ack_ch[$], res_cyc[$], res_chq[$], fd_cyc[$], ce_dat[$];
  logic [63:0] res_dat[$];
  int busy_cnt = 0;
  int a_idx;

  always @(negedge clk) begin
    if (conv_en) ce_dat.push_back(int'($signed(conv_in)));
    if (|ack) begin
      a_idx = -1;
      for (int i = 0; i < N; i++) if (ack[i]) a_idx = i;
      ack_cyc.push_back(cyc);
      ack_ch.push_back(a_idx);
    end
    if (res_valid) begin
      res_cyc.push_back(cyc);
      res_chq.push_back(int'(res_ch));
      res_dat.push_back(res_out);
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    ack_cyc.delete(); ack_ch.delete(); res_cyc.delete(); res_chq.delete();
    res_dat.delete(); fd_cyc.delete(); ce_dat.delete();
    busy_cnt = 0;
  endtask

  task automatic start_frame(output int t0);
    clk_Fs = 1'b1;
    t0 = cyc;
    tick();
    clk_Fs = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_fd_seen"}, 64'(frame_done), 64'd1);
    tick();
    check({tag, "_busy_fall"}, 64'(busy), 64'd0);
    repeat (3) tick();
  endtask

  function automatic logic [63:0] exp_fp(input int ch);
    case (ch)
      0: exp_fp = 64'hC014000000000000;
      1: exp_fp = 64'h4059000000000000;
      2: exp_fp = 64'h0000000000000000;
      default: exp_fp = 64'h40AFFE0000000000;
    endcase
  endfunction

  function automatic int dval(input int ch);
    case (ch)
      0: dval = -5;
      1: dval = 100;
      2: dval = 0;
      default: dval = 4095;
    endcase
  endfunction

  task automatic check_frame(input string tag, input int t_ack0, input int n, input logic [15:0] order);
    int ch;
    check({tag, "_nack"}, 64'(ack_cyc.size()), 64'(n));
    check({tag, "_nres"}, 64'(res_cyc.size()), 64'(n));
    check({tag, "_nconv"}, 64'(ce_dat.size()), 64'(n));
    check({tag, "_nfd"}, 64'(fd_cyc.size()), 64'd1);
    for (int k = 0; k < n; k++) begin
      ch = int'(order[k*4 +: 4]);
      check($sformatf("%s_ack_ch%0d", tag, k), 64'(ack_ch[k]), 64'(ch));
      check($sformatf("%s_ack_cyc%0d", tag, k), 64'(ack_cyc[k]), 64'(t_ack0 + k));
      check($sformatf("%s_conv_in%0d", tag, k), 64'(ce_dat[k]), 64'(dval(ch)));
      check($sformatf("%s_res_ch%0d", tag, k), 64'(res_chq[k]), 64'(ch));
      check($sformatf("%s_res_cyc%0d", tag, k), 64'(res_cyc[k]), 64'(t_ack0 + k + L));
      check($sformatf("%s_res_out%0d", tag, k), res_dat[k], exp_fp(ch));
    end
    check({tag, "_fd_cyc"}, 64'(fd_cyc[0]), 64'(t_ack0 + n + L + 1));
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_ctl"}, 64'({ack, conv_en, res_valid, frame_done, busy, overrun, res_ch}), 64'd0);
    check({tag, "_conv_in"}, 64'(conv_in), 64'd0);
    check({tag, "_res_out"}, res_out, 64'd0);
  endtask

  int t0, t1;

  initial begin
    rst_n = 1'b0; clk_Fs = 1'b0; ch_en = '0; req = '0;
    ch_data = {13'd4095, 13'd0, 13'd100, 13'h1FFB};
    repeat (3) tick();
    check_zero_outs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Full frame, all channels requesting
    ch_en = 4'b1111; req = 4'b1111; clear_log();
    start_frame(t0);
    tick(); tick();
    check("full_busy", 64'(busy), 64'd1);
    wait_done("full");
    check_frame("full", t0 + 2, 4, 16'h3210);

    // Round robin: 0,2 then 1 alone, then wrap starting at 2
    ch_en = 4'b0101; req = 4'b0101; clear_log();
    start_frame(t0); wait_done("rr1");
    check_frame("rr1", t0 + 2, 2, 16'h0020);
    ch_en = 4'b0010; req = 4'b1111; clear_log();
    start_frame(t0); wait_done("rr2");
    check_frame("rr2", t0 + 2, 1, 16'h0001);
    ch_en = 4'b1111; clear_log();
    start_frame(t0); wait_done("rr3");
    check_frame("rr3", t0 + 2, 4, 16'h1032);

    // Stalled requester on ch1
    ch_en = 4'b0011; req = 4'b0001; clear_log();
    start_frame(t0);
    repeat (10) tick();
    check("stall_nack", 64'(ack_cyc.size()), 64'd1);
    check("stall_ack0_cyc", 64'(ack_cyc[0]), 64'(t0 + 2));
    check("stall_ack0_ch", 64'(ack_ch[0]), 64'd0);
    check("stall_busy", 64'(busy), 64'd1);
    check("stall_no_fd", 64'(fd_cyc.size()), 64'd0);
    req = 4'b0011; t1 = cyc;
    wait_done("stall");
    check("stall_nack2", 64'(ack_cyc.size()), 64'd2);
    check("stall_ack1_ch", 64'(ack_ch[1]), 64'd1);
    check("stall_ack1_cyc", 64'(ack_cyc[1]), 64'(t1 + 1));
    check("stall_fd_cyc", 64'(fd_cyc[0]), 64'(t1 + 3 + L));
    check("stall_nres", 64'(res_cyc.size()), 64'd2);

    // Overrun: second Fs rise while busy
    ch_en = 4'b1111; req = 4'b1111; clear_log();
    start_frame(t0);
    tick(); tick();
    clk_Fs = 1'b1;
    tick();
    check("ovr_set", 64'(overrun), 64'd1);
    clk_Fs = 1'b0;
    wait_done("ovr");
    repeat (10) tick();
    check_frame("ovr", t0 + 2, 4, 16'h1032);
    check("ovr_sticky", 64'(overrun), 64'd1);

    // Reset with two conversions in flight
    clear_log();
    start_frame(t0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    clear_log();
    check_zero_outs("midrst");
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("midrst_nres", 64'(res_cyc.size()), 64'd0);
    check("midrst_nack", 64'(ack_cyc.size()), 64'd0);
    clear_log();
    start_frame(t0); wait_done("postrst");
    check_frame("postrst", t0 + 2, 4, 16'h3210);

    // Empty enable mask
    ch_en = 4'b0000; clear_log();
    start_frame(t0);
    repeat (5) tick();
    check("empty_nfd", 64'(fd_cyc.size()), 64'd1);
    check("empty_fd_cyc", 64'(fd_cyc[0]), 64'(t0 + 1));
    check("empty_nack", 64'(ack_cyc.size()), 64'd0);
    check("empty_nconv", 64'(ce_dat.size()), 64'd0);
    check("empty_busy", 64'(busy_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_conv_scheduler.md
Name: fp_conv_scheduler

Overview:
- Per-sample scheduler that shares one pipelined int-to-floating-point converter among N error channels (13-bit signed errors, reference minus ROM sample).
- Each rising edge of the sample strobe clk_Fs opens a frame. Every enabled channel is converted exactly once per frame, in round-robin order.
- Each result is returned with its channel tag, and a frame_done pulse marks the end of the frame.
- Sits between the per-channel error generators and the FP control-law datapath.

Parameters:
- N, 4, number of requesting channels (2..8)
- DW, 13, signed error width
- FPW, 64, floating-point result width
- CONV_LAT, 6, converter latency in clk cycles from conv_en to conv_result valid (1..15)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset; synchronous and active-low
- clk_Fs  in  1  sample strobe, synchronous to clk; rising edge detected internally
- ch_en  in  N  channel enable mask, latched at frame start
- req  in  N  level request per channel; held until ack
- ch_data  in  N*DW  flat signed data; channel i at [i*DW +: DW]
- ack  out  N  one-cycle pulse; channel's data captured
- conv_en  out  1  converter input valid
- conv_in  out  DW  signed data to converter
- conv_result  in  FPW  converter output, valid CONV_LAT cycles after conv_en
- res_valid  out  1  result strobe
- res_ch  out  3  channel of current result
- res_out  out  FPW  result (conv_result passed through)
- frame_done  out  1  one-cycle pulse at end of frame
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; a clk_Fs edge arrived while busy

Behaviour:
- Reset (rst_n=0 at posedge clk): all outputs 0. State goes to IDLE, rr_ptr=0, pending=0, tag pipeline cleared, Fs edge detector history set to 0.
- Reset applied mid-frame drops all in-flight conversions: no res_valid for them after reset.
- Fs edge detect: fs_q <= clk_Fs; fs_rise = clk_Fs & ~fs_q.
- State IDLE:
  - On fs_rise with ch_en != 0: pending <= ch_en, go to SERVE.
  - On fs_rise with ch_en == 0: pulse frame_done next cycle, stay IDLE.
- State SERVE, each cycle:
  - Eligible set = pending & req.
  - Pick the first eligible channel searching upward from rr_ptr, with wrap-around.
  - If a channel i is found: on the next clk, ack[i]=1, conv_en=1, conv_in=ch_data[i] (registered; one cycle grant-to-issue). Also pending[i] <= 0 and rr_ptr <= i+1 mod N.
  - Throughput is at most one issue per cycle.
  - A pending channel whose req is low is skipped and waited for; there is no timeout.
  - When pending becomes 0, go to DRAIN.
- State DRAIN: wait until the tag pipeline is empty (no conversions in flight), then go to DONE.
- State DONE: frame_done=1 for one cycle, then return to IDLE.
- Tag pipeline:
  - CONV_LAT-deep shift register of {valid, channel}, loaded with {conv_en, channel} in the same cycle conv_en is driven.
  - res_valid/res_ch come from the stage-CONV_LAT output; res_out = conv_result combinationally.
  - Hence res_valid occurs exactly CONV_LAT cycles after the matching conv_en, and results return in issue order.
- fs_rise while busy: overrun <= 1 (sticky until reset). The edge is otherwise ignored; the current frame completes normally.
- fs_rise in the same cycle as the DONE→IDLE transition counts as busy: overrun is set and no new frame starts.
- req on a channel not in pending (served already, or disabled) is ignored, with no ack, until a later frame.
- ch_en changes mid-frame have no effect on the current frame.
- conv_in is sign-preserving: no width change, passes DW bits as-is.

Test Plan:
- N=4, ch_en=4'b1111, req all high, data {-5,100,0,4095}, one clk_Fs rise:
  - ack pulses ch0,1,2,3 on four consecutive cycles, starting 1 cycle after the Fs edge is sampled.
  - res_valid on four consecutive cycles, each CONV_LAT after its conv_en, res_ch=0,1,2,3, with FP(-5), FP(100), FP(0), FP(4095).
  - frame_done after the last result; busy then falls.
- Round-robin: req only ch2 and ch0 high. First frame serves order 0,2. Then set rr_ptr via a frame that served ch1 last; the next frame's order starts at ch2 (wrap check).
- Stalled requester: ch_en=4'b0011, req[1] held low for 10 cycles:
  - ch0 acked immediately; FSM stays in SERVE.
  - ch1 acked 1 cycle after req[1] rises; frame_done follows CONV_LAT+2 cycles later.
- Overrun: second clk_Fs rise while busy sets overrun=1. The current frame's 4 results are all delivered, and no extra frame starts.
- Reset mid-frame: assert rst_n=0 with 2 conversions in flight. No res_valid is seen afterwards, all outputs are 0, and the next Fs edge starts a clean frame from ch0.
- ch_en=0: clk_Fs rise gives frame_done pulse, no ack, no conv_en, busy stays 0.
